// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit bridging the core to a req/gnt/rvalid data bus
//
// Accepts one load or store per access from the decoder and runs it on the data bus.
// Stores complete after the grant; loads also wait for the read response, then
// extract and extend the selected lane.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   mem_read_en / mem_write_en      access request from decoder (store wins if both)
//   L_type_data / S_type_data       load kind (LB/LH/LW/LBU/LHU) / store kind (SB/SH/SW)
//   addr, wdata                     effective byte address, store data
//   stall                           hold PC/regfile while an access is in flight
//   load_valid, load_data           extended load result, valid for one cycle
//   misaligned_err                  access rejected (misaligned or illegal kind)
//   dbus_req/we/addr/be/wdata       bus request, held stable until dbus_gnt
//   dbus_gnt, dbus_rvalid, dbus_rdata  bus grant and read response

module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic [2:0]  L_type_data,
  input  logic [2:0]  S_type_data,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        misaligned_err,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  kind_q;
  logic [1:0]  off_q;

  logic        is_store;
  logic        access;
  logic [2:0]  kind;
  logic        legal;
  logic        aligned;
  logic        launch;
  logic [3:0]  be_new;
  logic [31:0] wd_new;
  logic        stall_c;
  logic        err_c;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  // Request decode; a simultaneous load request is dropped in favour of the store.
  always_comb begin
    is_store = mem_write_en;
    access   = mem_write_en | mem_read_en;
    kind     = mem_write_en ? S_type_data : L_type_data;

    legal = 1'b0;
    if (is_store) begin
      case (kind)
        3'b000, 3'b001, 3'b010: legal = 1'b1;
        default:                legal = 1'b0;
      endcase
    end else begin
      case (kind)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        default:                                legal = 1'b0;
      endcase
    end

    // kind[1:0] encodes the size for every legal code: 00 byte, 01 half, 10 word.
    case (kind[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase

    launch = access & legal & aligned;

    case (kind[1:0])
      2'b00:   be_new = 4'b0001 << addr[1:0];
      2'b01:   be_new = 4'b0011 << {addr[1], 1'b0};
      default: be_new = 4'b1111;
    endcase

    // Narrow stores are replicated so the slave can pick any lane via byte enables.
    case (kind[1:0])
      2'b00:   wd_new = {4{wdata[7:0]}};
      2'b01:   wd_new = {2{wdata[15:0]}};
      default: wd_new = wdata;
    endcase
  end

  // Load lane selection and extension from the latched offset and kind.
  always_comb begin
    case (off_q)
      2'b00:   rd_byte = dbus_rdata[7:0];
      2'b01:   rd_byte = dbus_rdata[15:8];
      2'b10:   rd_byte = dbus_rdata[23:16];
      default: rd_byte = dbus_rdata[31:24];
    endcase
    rd_half = off_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];

    case (kind_q)
      3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  rd_ext = {24'd0, rd_byte};
      3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
      3'b101:  rd_ext = {16'd0, rd_half};
      default: rd_ext = dbus_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    stall_c = 1'b0;
    err_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (launch) begin
            state_d = REQ;
            stall_c = 1'b1;
          end else begin
            err_c = 1'b1;
          end
        end
      end
      REQ: begin
        stall_c = 1'b1;
        if (dbus_gnt) state_d = dbus_we ? DONE : RESP;
      end
      RESP: begin
        stall_c = 1'b1;
        if (dbus_rvalid) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The IDLE-cycle outputs are combinational on decoder inputs, so reset gates them directly.
  assign stall          = stall_c & rst_n;
  assign misaligned_err = err_c & rst_n;
  assign dbus_req       = (state_q == REQ);
  assign load_valid     = (state_q == DONE) & ~dbus_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      kind_q     <= 3'd0;
      off_q      <= 2'd0;
      dbus_we    <= 1'b0;
      dbus_addr  <= 32'd0;
      dbus_be    <= 4'd0;
      dbus_wdata <= 32'd0;
      load_data  <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && launch) begin
        kind_q     <= kind;
        off_q      <= addr[1:0];
        dbus_we    <= is_store;
        dbus_addr  <= {addr[31:2], 2'b00};
        dbus_be    <= be_new;
        dbus_wdata <= wd_new;
      end
      if (state_q == RESP && dbus_rvalid) begin
        load_data <= rd_ext;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read_en, mem_write_en;
  logic [2:0]  L_type_data, S_type_data;
  logic [31:0] addr, wdata;
  logic        stall, load_valid, misaligned_err;
  logic [31:0] load_data;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_gnt, dbus_rvalid;
  logic [31:0] dbus_rdata;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .L_type_data(L_type_data), .S_type_data(S_type_data),
    .addr(addr), .wdata(wdata),
    .stall(stall), .load_valid(load_valid), .load_data(load_data),
    .misaligned_err(misaligned_err),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
    .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Expected outputs for the current cycle, set by the stimulus just after posedge.
  logic        chk_on = 1'b0;
  logic        exp_stall, exp_err, exp_req, exp_lv, exp_we;
  logic        bus_chk, wd_chk;
  logic [31:0] exp_ld, exp_addr, exp_wd;
  logic [3:0]  exp_be;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("stall", {31'd0, stall}, {31'd0, exp_stall});
      check("misaligned_err", {31'd0, misaligned_err}, {31'd0, exp_err});
      check("dbus_req", {31'd0, dbus_req}, {31'd0, exp_req});
      check("load_valid", {31'd0, load_valid}, {31'd0, exp_lv});
      check("load_data", load_data, exp_ld);
      if (bus_chk) begin
        check("dbus_addr", dbus_addr, exp_addr);
        check("dbus_be", {28'd0, dbus_be}, {28'd0, exp_be});
        check("dbus_we", {31'd0, dbus_we}, {31'd0, exp_we});
        if (wd_chk) check("dbus_wdata", dbus_wdata, exp_wd);
      end
    end
  end

  // Access size in bytes, 0 for an illegal kind code.
  function automatic int nbytes(input bit st, input logic [2:0] k);
    if (st) begin
      case (k)
        3'd0: return 1;
        3'd1: return 2;
        3'd2: return 4;
        default: return 0;
      endcase
    end
    case (k)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] k, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] v;
    int n;
    n = nbytes(1'b0, k);
    v = rd >> ((a % 4) * 8);
    if (n == 1) begin
      v = v & 32'hFF;
      if (k == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (n == 2) begin
      v = v & 32'hFFFF;
      if (k == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    exp_stall = 1'b0; exp_err = 1'b0; exp_req = 1'b0; exp_lv = 1'b0; bus_chk = 1'b0;
  endtask

  // One access starting in an IDLE cycle; returns in the following IDLE cycle.
  task automatic run(input bit st, input bit ld, input logic [2:0] kind,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int gdel, input bit early_rv, input int rdel,
                     input logic [31:0] rd, input bit has_lit, input logic [31:0] lit);
    int  n;
    bit  store;
    bit  valid;
    store = st;
    n     = nbytes(st, kind);
    valid = (st || ld) && n != 0 && (a % n) == 0;

    mem_write_en = st;
    mem_read_en  = ld;
    S_type_data  = kind;
    L_type_data  = (st && ld) ? 3'b011 : kind;
    addr         = a;
    wdata        = wd;
    set_idle();
    exp_stall = valid;
    exp_err   = !valid;
    step();
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    set_idle();
    if (!valid) return;

    exp_addr = a & 32'hFFFF_FFFC;
    exp_be   = 4'(((1 << n) - 1) << (a % 4));
    exp_we   = store;
    wd_chk   = store;
    if (n == 1)      exp_wd = 32'h0101_0101 * wd[7:0];
    else if (n == 2) exp_wd = 32'h0001_0001 * wd[15:0];
    else             exp_wd = wd;

    for (int i = 0; i <= gdel; i++) begin
      exp_req = 1'b1; exp_stall = 1'b1; bus_chk = 1'b1;
      dbus_gnt    = (i == gdel);
      dbus_rvalid = (i == gdel) && early_rv;
      dbus_rdata  = 32'hFFFF_FFFF;
      step();
    end
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
    set_idle();

    if (!store) begin
      for (int j = 0; j <= rdel; j++) begin
        exp_stall   = 1'b1;
        dbus_rvalid = (j == rdel);
        dbus_rdata  = rd;
        step();
      end
      dbus_rvalid = 1'b0;
      set_idle();
      exp_ld = model_load(kind, a, rd);
    end

    exp_lv = !store;
    if (has_lit) begin
      @(negedge clk);
      check("literal_load", load_data, lit);
      @(posedge clk);
      #1;
    end else begin
      step();
    end
    set_idle();
  endtask

  initial begin
    rst_n = 1'b0;
    mem_read_en = 1'b1; mem_write_en = 1'b0;
    L_type_data = 3'b010; S_type_data = 3'b000;
    addr = 32'd0; wdata = 32'd0;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = 32'd0;
    set_idle();
    exp_ld = 32'd0; exp_addr = 32'd0; exp_be = 4'd0; exp_we = 1'b0; exp_wd = 32'd0;
    bus_chk = 1'b1; wd_chk = 1'b1;
    chk_on = 1'b1;
    step();
    step();
    rst_n = 1'b1; mem_read_en = 1'b0;
    set_idle();
    step();

    //    st ld kind    addr           wdata          g  erv r rdata          lit lit_val
    run(1, 0, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 2, 0, 0, 32'd0,         0, 32'd0);
    run(1, 0, 3'd0, 32'h0000_0103, 32'h0000_00A5, 0, 0, 0, 32'd0,         0, 32'd0);
    run(1, 0, 3'd1, 32'h0000_0102, 32'h1234_BEEF, 1, 0, 0, 32'd0,         0, 32'd0);
    run(1, 1, 3'd1, 32'h0000_0400, 32'h0000_C0DE, 0, 0, 0, 32'd0,         0, 32'd0);

    // Stray bus handshakes while idle must not move the FSM or load_data.
    dbus_gnt = 1'b1; dbus_rvalid = 1'b1; dbus_rdata = 32'hCAFE_F00D;
    step();
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
    step();

    run(0, 1, 3'd0, 32'h0000_0202, 32'd0, 0, 0, 1, 32'h0080_0000, 1, 32'hFFFF_FF80);
    run(0, 1, 3'd4, 32'h0000_0202, 32'd0, 1, 0, 0, 32'h0080_0000, 1, 32'h0000_0080);
    run(0, 1, 3'd5, 32'h0000_0202, 32'd0, 0, 0, 0, 32'h8001_0000, 1, 32'h0000_8001);
    run(0, 1, 3'd1, 32'h0000_0200, 32'd0, 0, 0, 2, 32'h1234_F00D, 1, 32'hFFFF_F00D);
    run(0, 1, 3'd0, 32'h0000_0301, 32'd0, 0, 0, 0, 32'h0000_7F00, 1, 32'h0000_007F);
    run(0, 1, 3'd2, 32'h0000_0201, 32'd0, 0, 0, 0, 32'd0,         0, 32'd0);
    run(0, 1, 3'd1, 32'h0000_0201, 32'd0, 0, 0, 0, 32'd0,         0, 32'd0);
    run(1, 0, 3'd2, 32'h0000_0102, 32'h1111_1111, 0, 0, 0, 32'd0, 0, 32'd0);
    run(0, 1, 3'd3, 32'h0000_0200, 32'd0, 0, 0, 0, 32'd0,         0, 32'd0);
    run(1, 0, 3'd4, 32'h0000_0200, 32'd0, 0, 0, 0, 32'd0,         0, 32'd0);
    run(0, 1, 3'd2, 32'h0000_0204, 32'd0, 0, 1, 2, 32'h1234_5678, 1, 32'h1234_5678);
    step();

    // Reset while waiting for the read response; a late rvalid must be ignored.
    mem_read_en = 1'b1; L_type_data = 3'b010; addr = 32'h0000_0300;
    set_idle(); exp_stall = 1'b1;
    step();
    mem_read_en = 1'b0;
    set_idle();
    exp_req = 1'b1; exp_stall = 1'b1; bus_chk = 1'b1;
    exp_addr = 32'h0000_0300; exp_be = 4'hF; exp_we = 1'b0; wd_chk = 1'b0;
    dbus_gnt = 1'b1;
    step();
    dbus_gnt = 1'b0;
    set_idle();
    exp_stall = 1'b1;
    #2;
    rst_n = 1'b0;
    set_idle();
    exp_ld = 32'd0;
    bus_chk = 1'b1; wd_chk = 1'b1;
    exp_addr = 32'd0; exp_be = 4'd0; exp_we = 1'b0; exp_wd = 32'd0;
    step();
    dbus_rvalid = 1'b1; dbus_rdata = 32'h5555_5555;
    step();
    rst_n = 1'b1;
    set_idle();
    step();
    dbus_rvalid = 1'b0;
    step();

    run(0, 1, 3'd4, 32'h0000_0303, 32'd0, 0, 0, 0, 32'hAB00_0000, 1, 32'h0000_00AB);
    step();

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
